// File: rtl/booth_mult_seq.sv
// Sequencer that feeds operand pairs to the Booth encoder, pulses start, waits a fixed latency and holds the product.
// Optional answer self-check against a behavioural product: define BOOTH_MULT_SELFCHECK_EN.
module booth_mult_seq #(
    parameter int MBITS     = 12,
    parameter int NBITS     = 8,
    parameter int COUNTBITS = 4,
    parameter int LATENCY   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MBITS-1:0]       in_mpd,
    input  logic [NBITS-1:0]       in_mpr,
    output logic [MBITS-1:0]       mpd_o,
    output logic [NBITS-1:0]       mpr_o,
    output logic                   start_o,
    input  logic [MBITS+NBITS-1:0] answer_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MBITS+NBITS-1:0] out_prod,
    output logic                   busy,
    output logic                   err
);

    localparam int PBITS = MBITS + NBITS;

    generate
        if (LATENCY < 1 || LATENCY > (2 ** COUNTBITS) - 1) begin : g_bad_latency
            $error("booth_mult_seq: LATENCY must be in 1..2**COUNTBITS-1");
        end
        if (NBITS >= MBITS) begin : g_bad_widths
            $error("booth_mult_seq: NBITS must be smaller than MBITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD
    } state_t;

    state_t               state;
    logic [COUNTBITS-1:0] count;
    logic                 capture;

    assign capture  = (state == WAIT) && (count == COUNTBITS'(1));
    // Gated by reset so the port reads 0 during the reset cycle and 1 right after.
    assign in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            mpd_o     <= '0;
            mpr_o     <= '0;
            start_o   <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mpd_o   <= in_mpd;
                        mpr_o   <= in_mpr;
                        start_o <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    start_o <= 1'b0;
                    count   <= COUNTBITS'(LATENCY);
                    state   <= WAIT;
                end
                WAIT: begin
                    count <= count - COUNTBITS'(1);
                    if (capture) begin
                        out_prod  <= answer_i;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOTH_MULT_SELFCHECK_EN
    logic signed [PBITS-1:0] mpd_ext;
    logic signed [PBITS-1:0] mpr_ext;
    logic signed [PBITS-1:0] shadow;

    assign mpd_ext = PBITS'($signed(mpd_o));
    assign mpr_ext = PBITS'($signed(mpr_o));
    assign shadow  = mpd_ext * mpr_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (capture && (answer_i != shadow)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed vector table, corner sequences and random operands vs an integer model.
module tb_booth_mult_seq;

    localparam int MB = 12;
    localparam int NB = 8;
    localparam int CB = 4;
    localparam int L  = 3;
    localparam int PB = MB + NB;

`ifdef BOOTH_MULT_SELFCHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [MB-1:0] in_mpd;
    logic [NB-1:0] in_mpr;
    logic [MB-1:0] mpd_o;
    logic [NB-1:0] mpr_o;
    logic          start_o;
    logic [PB-1:0] answer_i;
    logic          out_valid;
    logic          out_ready;
    logic [PB-1:0] out_prod;
    logic          busy;
    logic          err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int since = 0;
    bit            force_bad  = 1'b0;
    logic [PB-1:0] forced_val = '0;

    always #5 clk = ~clk;

    booth_mult_seq #(
        .MBITS(MB),
        .NBITS(NB),
        .COUNTBITS(CB),
        .LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mpd(in_mpd),
        .in_mpr(in_mpr),
        .mpd_o(mpd_o),
        .mpr_o(mpr_o),
        .start_o(start_o),
        .answer_i(answer_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod(out_prod),
        .busy(busy),
        .err(err)
    );

    // Encoder/Wallace stand-in: the product is only valid LATENCY cycles after start, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) since <= 0;
        else if (start_o) since <= 1;
        else if (since != 0 && since < 100) since <= since + 1;
    end

    always_comb begin
        answer_i = PB'(32'h5A5A5);
        if (since == L)
            answer_i = force_bad ? forced_val
                                 : PB'(int'($signed(mpd_o)) * int'($signed(mpr_o)));
    end

    function automatic logic [PB-1:0] ref_prod(input logic [MB-1:0] a, input logic [NB-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return PB'(sa * sb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives and samples on negedges; acc_cyc is the cycle stamp of the accept edge.
    task automatic do_op(input logic [MB-1:0] a, input logic [NB-1:0] b, input logic [PB-1:0] exp,
                         input int hold, input bit intrude, input string tag, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        in_mpd   = a;
        in_mpr   = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, " accept timeout"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        chk({tag, " start_o"}, 64'(start_o), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        chk({tag, " operands"}, {32'(mpd_o), 32'(mpr_o)}, {32'(a), 32'(b)});
        for (int k = 1; k <= L; k++) begin
            if (intrude && k <= 2) begin
                in_valid  = 1'b1;
                in_mpd    = ~a;
                in_mpr    = ~b;
                out_ready = 1'b1;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            @(negedge clk);
            chk({tag, " wait start/valid"}, {62'd0, start_o, out_valid}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_prod"}, 64'(out_prod), 64'(exp));
        chk({tag, " in_ready in hold"}, 64'(in_ready), 64'd0);
        if (intrude) chk({tag, " operands kept"}, {32'(mpd_o), 32'(mpr_o)}, {32'(a), 32'(b)});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold"}, {32'(out_prod), 30'd0, out_valid, in_ready}, {32'(exp), 32'd2});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " release"}, {61'd0, out_valid, busy, in_ready}, 64'd1);
    endtask

    typedef struct {
        logic [MB-1:0] a;
        logic [NB-1:0] b;
        logic [PB-1:0] exp;
        int            hold;
    } vec_t;

    vec_t vecs[4];
    int   acc[4];
    int   t0;
    int   seen;

    initial begin
        vecs[0] = '{a: 12'hFFB, b: 8'h03, exp: 20'hFFFF1, hold: 0};
        vecs[1] = '{a: 12'h064, b: 8'hFE, exp: 20'hFFF38, hold: 5};
        vecs[2] = '{a: 12'h7FF, b: 8'h7F, exp: 20'h3F781, hold: 0};
        vecs[3] = '{a: 12'h800, b: 8'h80, exp: 20'h40000, hold: 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mpd    = '0;
        in_mpr    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset ctl", {60'd0, start_o, out_valid, busy, err}, 64'd0);
        chk("reset data", {4'd0, mpd_o, mpr_o, out_prod}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 4; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, 1'b0, $sformatf("vec%0d", i), acc[i]);
        chk("back-to-back gap", 64'(acc[3] - acc[2]), 64'(L + 3));

        // Reset in the second WAIT cycle abandons the operation.
        in_valid = 1'b1;
        in_mpd   = 12'h123;
        in_mpr   = 8'h45;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy/in_ready", {62'd0, busy, in_ready}, 64'd1);
        chk("abort data", {4'd0, mpd_o, mpr_o, out_prod}, 64'd0);
        seen = 0;
        for (int k = 0; k < L + 3; k++) begin
            if (out_valid || start_o) seen++;
            @(negedge clk);
        end
        chk("abort no product", 64'(seen), 64'd0);
        do_op(12'h00A, 8'hF9, 20'hFFFBA, 1, 1'b0, "after-abort", t0);

        do_op(12'h321, 8'h11, ref_prod(12'h321, 8'h11), 0, 1'b1, "intrude", t0);
        chk("err before selfcheck", 64'(err), 64'd0);

        force_bad  = 1'b1;
        forced_val = 20'h0000D;
        do_op(12'd3, 8'd4, 20'h0000D, 0, 1'b0, "bad-answer", t0);
        force_bad = 1'b0;
        chk("err after bad", 64'(err), 64'(EXP_ERR));
        do_op(12'd3, 8'd4, 20'h0000C, 0, 1'b0, "good-answer", t0);
        chk("err sticky", 64'(err), 64'(EXP_ERR));

        for (int r = 0; r < 20; r++) begin
            logic [MB-1:0] ra;
            logic [NB-1:0] rb;
            ra = MB'($urandom);
            rb = NB'($urandom);
            do_op(ra, rb, ref_prod(ra, rb), int'($urandom_range(0, 2)), 1'b0, $sformatf("rand%0d", r), t0);
        end
        chk("err after random", 64'(err), 64'(EXP_ERR));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("err cleared by reset", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequencer placed directly upstream of the Booth partial-product encoder.
- Accepts signed operand pairs over a valid/ready handshake and registers them onto the encoder's mpd/mpr inputs.
- Issues a one-cycle start pulse, then waits a fixed latency for the encoder and Wallace tree.
- Captures the product and holds it on an output valid/ready port until it is consumed.

Parameters:
- MBITS, 12: multiplicand width, signed two's complement.
- NBITS, 8: multiplier width, signed, NBITS < MBITS.
- COUNTBITS, 4: width of the latency counter.
- LATENCY, 3: clk cycles from start_o high to answer_i valid; legal range 1..2^COUNTBITS-1.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand pair offered.
- in_ready, output, 1: sequencer can accept an operand pair.
- in_mpd, input, MBITS: multiplicand.
- in_mpr, input, NBITS: multiplier.
- mpd_o, output, MBITS: registered multiplicand to the encoder.
- mpr_o, output, NBITS: registered multiplier to the encoder.
- start_o, output, 1: start pulse to the encoder.
- answer_i, input, MBITS+NBITS: product from the Wallace tree.
- out_valid, output, 1: product held on out_prod.
- out_ready, input, 1: consumer accepts the product.
- out_prod, output, MBITS+NBITS: captured signed product.
- busy, output, 1: high in any state other than IDLE.
- err, output, 1: sticky mismatch flag (see Optional Feature).

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. start_o=0, out_valid=0, busy=0, err=0. mpd_o, mpr_o and out_prod reset to 0. Counter reset to 0. State reset to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_mpd→mpd_o and in_mpr→mpr_o, go to LAUNCH.
  - Inputs are otherwise ignored.
- LAUNCH:
  - start_o=1 for exactly this one cycle; mpd_o/mpr_o are already stable.
  - Load counter with LATENCY, go to WAIT.
- WAIT:
  - start_o=0; counter decrements each cycle.
  - When the counter reaches 1: capture answer_i→out_prod on that edge, set out_valid, go to HOLD.
  - WAIT therefore lasts exactly LATENCY cycles.
- HOLD:
  - out_valid=1; out_prod stable.
  - On out_ready: clear out_valid, go to IDLE.
  - in_ready=0; back-to-back operands are accepted one cycle after the out_ready handshake.
- Latency: accept at edge T → start_o high in cycle T+1 → out_valid first high after edge T+1+LATENCY.
- Throughput: at best one product per LATENCY+3 cycles.
- mpd_o/mpr_o hold their last values after completion; they change only on a new accept.
- Arithmetic: out_prod is a bit-exact copy of answer_i. It is the full signed product (MBITS+NBITS bits, no truncation).
- Boundary and error cases:
  - in_valid while busy: no effect; the offer must remain asserted to be taken.
  - out_ready without out_valid: ignored.
  - Reset asserted in any state: the operation is abandoned, no product is emitted, start_o drops the same edge, and the state returns to IDLE.
  - LATENCY out of range: an elaboration error is raised via a generate-time check.

Optional Feature:
- Macro: BOOTH_MULT_SELFCHECK_EN.
- When defined:
  - A shadow behavioral product $signed(mpd_o)*$signed(mpr_o) is computed combinationally.
  - It is compared with answer_i on the capture edge.
  - On mismatch, err is set and stays set until reset.
- When undefined: no comparator is built and err is tied to 0.
- All other behaviour is identical in both configurations.

Test Plan:
- Reset, then mpd=12'hFFB (-5), mpr=8'h03 with an ideal model on answer_i → start_o high one cycle after accept, out_valid after LATENCY cycles, out_prod=20'hFFFF1 (-15).
- mpd=12'h064 (100), mpr=8'hFE (-2), out_ready held low for 5 cycles → out_prod=20'hFFF38 stays stable with out_valid=1 and in_ready=0 throughout; returns to IDLE on the out_ready cycle.
- Extremes:
  - mpd=12'h7FF, mpr=8'h7F → out_prod=20'h3F781.
  - mpd=12'h800, mpr=8'h80 → out_prod=20'h40000.
  - Both issued back-to-back with out_ready=1 → gap of exactly LATENCY+3 cycles between the two in_ready&in_valid accepts.
- Reset asserted during WAIT (second cycle) → out_valid never rises, busy=0 and in_ready=1 the cycle after reset deasserts; the next operand completes normally.
- in_valid pulsed during WAIT with a different operand → ignored; mpd_o/mpr_o unchanged, out_prod reflects the first operand only.
- Self-check:
  - With BOOTH_MULT_SELFCHECK_EN, mpd=3, mpr=4, answer_i forced to 20'h0000D → err=1 after capture and remains 1 across later correct products until reset.
  - Without the macro, the same stimulus gives err=0.
